// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_if
// Description : Pipeline-side and RAM-side signal bundle of the memory port
//               sequencer (IF fetch, MEM load/store, byte-wide RAM pins).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_flush_i;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [1:0]  mem_len_i;
   logic [31:0] mem_wdata_i;
   logic [7:0]  mem_din_i;
   logic        io_buffer_full_i;
   logic [31:0] mem_a_o;
   logic [7:0]  mem_dout_o;
   logic        mem_wr_o;
   logic        if_done_o;
   logic [31:0] if_inst_o;
   logic        mem_done_o;
   logic [31:0] mem_rdata_o;
   logic        busy_o;

   modport master (
      output if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_addr_i,
             mem_len_i, mem_wdata_i, mem_din_i, io_buffer_full_i,
      input  mem_a_o, mem_dout_o, mem_wr_o, if_done_o, if_inst_o, mem_done_o,
             mem_rdata_o, busy_o
   );

   modport slave (
      input  if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_addr_i,
             mem_len_i, mem_wdata_i, mem_din_i, io_buffer_full_i,
      output mem_a_o, mem_dout_o, mem_wr_o, if_done_o, if_inst_o, mem_done_o,
             mem_rdata_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates the byte-wide RAM/IO port between IF and MEM and
//               sequences each request into pipelined byte accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input  wire logic clk,
   input  wire logic rst,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t      r_state, w_state;
   logic        r_owner_if, w_owner_if;
   logic [31:0] r_addr, w_addr;
   logic [2:0]  r_len, w_len;
   logic [31:0] r_wdata, w_wdata;
   logic        r_io, w_io;
   logic [2:0]  r_issue, w_issue;
   logic [1:0]  r_cap, w_cap;
   logic        r_addr_vld, w_addr_vld;
   logic        r_din_vld, w_din_vld;
   logic [31:0] r_buf, w_buf;

   logic [31:0] r_mem_a, w_mem_a;
   logic [7:0]  r_mem_dout, w_mem_dout;
   logic        r_mem_wr, w_mem_wr;
   logic        r_if_done, w_if_done;
   logic [31:0] r_if_inst, w_if_inst;
   logic        r_mem_done, w_mem_done;
   logic [31:0] r_mem_rdata, w_mem_rdata;
   logic        r_busy, w_busy;

   logic        w_mem_go;
   logic        w_if_go;
   logic [2:0]  w_req_len;
   logic [31:0] w_assembled;
   logic [31:0] w_cur_addr;
   logic [7:0]  w_wbyte;
   logic        w_stall;

   // A requester whose done pulse is showing still has its stale req asserted.
   assign w_mem_go    = bus.mem_req_i && !r_mem_done;
   assign w_if_go     = bus.if_req_i && !bus.if_flush_i && !r_if_done;
   assign w_req_len   = (bus.mem_len_i == 2'b00) ? 3'd1 :
                        (bus.mem_len_i == 2'b01) ? 3'd2 : 3'd4;
   assign w_assembled = r_buf | ({24'd0, bus.mem_din_i} << {r_cap, 3'b000});
   assign w_cur_addr  = r_addr + {29'd0, r_issue};
   assign w_wbyte     = 8'(r_wdata >> {r_issue[1:0], 3'b000});
   assign w_stall     = r_io && bus.io_buffer_full_i;

   always_comb begin
      w_state     = r_state;
      w_owner_if  = r_owner_if;
      w_addr      = r_addr;
      w_len       = r_len;
      w_wdata     = r_wdata;
      w_io        = r_io;
      w_issue     = r_issue;
      w_cap       = r_cap;
      w_addr_vld  = 1'b0;
      w_din_vld   = r_addr_vld;
      w_buf       = r_buf;
      w_mem_a     = 32'd0;
      w_mem_dout  = r_mem_dout;
      w_mem_wr    = 1'b0;
      w_if_done   = 1'b0;
      w_if_inst   = r_if_inst;
      w_mem_done  = 1'b0;
      w_mem_rdata = r_mem_rdata;
      w_busy      = r_busy;

      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (w_mem_go || w_if_go) begin
               w_busy   = 1'b1;
               w_cap    = 2'd0;
               w_buf    = 32'd0;
               w_issue  = 3'd1;
               w_mem_a  = w_mem_go ? bus.mem_addr_i : bus.if_addr_i;
               w_addr   = w_mem_a;
               w_owner_if = !w_mem_go;
               w_len    = w_mem_go ? w_req_len : 3'd4;
               w_wdata  = bus.mem_wdata_i;
               w_io     = w_mem_go && bus.mem_we_i && (bus.mem_addr_i[17:16] == IO_SEL);
               if (w_mem_go && bus.mem_we_i) begin
                  w_state = ST_WRITE;
                  if (w_io && bus.io_buffer_full_i) begin
                     w_issue = 3'd0;
                  end else begin
                     w_mem_dout = bus.mem_wdata_i[7:0];
                     w_mem_wr   = 1'b1;
                  end
               end else begin
                  w_state    = ST_READ;
                  w_addr_vld = 1'b1;
               end
            end
         end

         ST_READ: begin
            if (r_owner_if && bus.if_flush_i) begin
               w_state   = ST_IDLE;
               w_busy    = 1'b0;
               w_din_vld = 1'b0;
            end else begin
               if (r_issue < r_len) begin
                  w_mem_a    = w_cur_addr;
                  w_addr_vld = 1'b1;
                  w_issue    = r_issue + 3'd1;
               end
               // mem_din_i now carries the byte addressed in the previous cycle
               if (r_din_vld) begin
                  w_buf = w_assembled;
                  w_cap = r_cap + 2'd1;
                  if ({1'b0, r_cap} == (r_len - 3'd1)) begin
                     w_state = ST_IDLE;
                     w_busy  = 1'b0;
                     if (r_owner_if) begin
                        w_if_done = 1'b1;
                        w_if_inst = w_assembled;
                     end else begin
                        w_mem_done  = 1'b1;
                        w_mem_rdata = w_assembled;
                     end
                  end
               end
            end
         end

         ST_WRITE: begin
            if (r_issue == r_len) begin
               w_state    = ST_IDLE;
               w_busy     = 1'b0;
               w_mem_done = 1'b1;
            end else if (w_stall) begin
               w_mem_a = w_cur_addr;
            end else begin
               w_mem_a    = w_cur_addr;
               w_mem_dout = w_wbyte;
               w_mem_wr   = 1'b1;
               w_issue    = r_issue + 3'd1;
            end
         end

         default: begin
            w_state = ST_IDLE;
            w_busy  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_owner_if  <= 1'b0;
         r_addr      <= 32'd0;
         r_len       <= 3'd0;
         r_wdata     <= 32'd0;
         r_io        <= 1'b0;
         r_issue     <= 3'd0;
         r_cap       <= 2'd0;
         r_addr_vld  <= 1'b0;
         r_din_vld   <= 1'b0;
         r_buf       <= 32'd0;
         r_mem_a     <= 32'd0;
         r_mem_dout  <= 8'd0;
         r_mem_wr    <= 1'b0;
         r_if_done   <= 1'b0;
         r_if_inst   <= 32'd0;
         r_mem_done  <= 1'b0;
         r_mem_rdata <= 32'd0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_owner_if  <= w_owner_if;
         r_addr      <= w_addr;
         r_len       <= w_len;
         r_wdata     <= w_wdata;
         r_io        <= w_io;
         r_issue     <= w_issue;
         r_cap       <= w_cap;
         r_addr_vld  <= w_addr_vld;
         r_din_vld   <= w_din_vld;
         r_buf       <= w_buf;
         r_mem_a     <= w_mem_a;
         r_mem_dout  <= w_mem_dout;
         r_mem_wr    <= w_mem_wr;
         r_if_done   <= w_if_done;
         r_if_inst   <= w_if_inst;
         r_mem_done  <= w_mem_done;
         r_mem_rdata <= w_mem_rdata;
         r_busy      <= w_busy;
      end
   end

   assign bus.mem_a_o     = r_mem_a;
   assign bus.mem_dout_o  = r_mem_dout;
   assign bus.mem_wr_o    = r_mem_wr;
   assign bus.if_done_o   = r_if_done;
   assign bus.if_inst_o   = r_if_inst;
   assign bus.mem_done_o  = r_mem_done;
   assign bus.mem_rdata_o = r_mem_rdata;
   assign bus.busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl with a byte RAM device and a
//               transaction-level reference of expected bus activity.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_ctrl_if bus();
   mem_ctrl #(.IO_SEL(2'b11)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] ram     [256];
   logic [7:0] ref_mem [256];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; the RAM device sees the previous cycle's pins.
   task automatic tick();
      logic [31:0] a;
      logic        w;
      logic [7:0]  d;
      a = bus.mem_a_o;
      w = bus.mem_wr_o;
      d = bus.mem_dout_o;
      @(posedge clk);
      #1;
      if (w) ram[a[7:0]] = d;
      bus.mem_din_i = ram[a[7:0]];
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, input int len);
      logic [31:0] v;
      logic [31:0] ai;
      v = 32'd0;
      for (int i = 0; i < len; i++) begin
         ai = a + 32'(i);
         v  = v | ({24'd0, ref_mem[ai[7:0]]} << (8 * i));
      end
      return v;
   endfunction

   task automatic run_txn(input bit is_if, input bit we, input logic [31:0] a,
                          input logic [1:0] lc, input logic [31:0] wd,
                          input logic [7:0] fmask, input bit rnd_full);
      int          len, exp_done, n, idx;
      bit          io;
      bit          full_seq[64];
      int          issue_at[4];
      logic [31:0] exp_data, ai;
      len = is_if ? 4 : (lc == 2'b00) ? 1 : (lc == 2'b01) ? 2 : 4;
      io  = !is_if && we && (a[17:16] == 2'b11);
      for (int j = 0; j < 64; j++)
         full_seq[j] = (j < 8) ? fmask[j] : (rnd_full && j < 24 && $urandom_range(1) == 1);
      exp_data = 32'd0;
      exp_done = len + 2;
      if (we) begin
         // a byte goes out at every edge that is not IO back-pressured
         n = 0;
         for (int j = 0; j < 64 && n < len; j++)
            if (!(io && full_seq[j])) begin
               issue_at[n] = j + 1;
               n++;
            end
         exp_done = issue_at[len-1] + 1;
      end else begin
         exp_data = model_read(a, len);
      end
      if (is_if) begin
         bus.if_req_i  = 1'b1;
         bus.if_addr_i = a;
      end else begin
         bus.mem_req_i   = 1'b1;
         bus.mem_we_i    = we;
         bus.mem_addr_i  = a;
         bus.mem_len_i   = lc;
         bus.mem_wdata_i = wd;
      end
      bus.io_buffer_full_i = full_seq[0];
      bus.if_flush_i = is_if ? 1'b0 : 1'($urandom_range(1));
      for (int k = 1; k <= exp_done; k++) begin
         tick();
         bus.io_buffer_full_i = full_seq[k];
         bus.if_flush_i = is_if ? 1'b0 : 1'($urandom_range(1));
         if (we) begin
            idx = -1;
            for (int i = 0; i < len; i++) if (issue_at[i] == k) idx = i;
            if (k < exp_done) begin
               check("wr_strobe", 32'(bus.mem_wr_o), 32'(idx >= 0));
               if (idx >= 0) begin
                  ai = a + 32'(idx);
                  check("wr_addr", bus.mem_a_o, ai);
                  check("wr_data", 32'(bus.mem_dout_o), (wd >> (8 * idx)) & 32'hff);
               end
            end
         end else if (k <= len) begin
            ai = a + 32'(k - 1);
            check("rd_addr", bus.mem_a_o, ai);
            check("rd_wr", 32'(bus.mem_wr_o), 32'd0);
         end
         check(is_if ? "if_done" : "mem_done",
               32'(is_if ? bus.if_done_o : bus.mem_done_o), 32'(k == exp_done));
         check("other_done", 32'(is_if ? bus.mem_done_o : bus.if_done_o), 32'd0);
         check("busy", 32'(bus.busy_o), 32'(k < exp_done));
      end
      if (!we) check(is_if ? "if_inst" : "mem_rdata", is_if ? bus.if_inst_o : bus.mem_rdata_o, exp_data);
      check("done_addr", bus.mem_a_o, 32'd0);
      check("done_wr", 32'(bus.mem_wr_o), 32'd0);
      if (we)
         for (int i = 0; i < len; i++) begin
            ai = a + 32'(i);
            ref_mem[ai[7:0]] = 8'(wd >> (8 * i));
         end
      // req was still high in the done cycle; it must not have been regranted
      bus.if_req_i = 1'b0;
      bus.mem_req_i = 1'b0;
      bus.io_buffer_full_i = 1'b0;
      bus.if_flush_i = 1'b0;
      tick();
      check("idle_busy", 32'(bus.busy_o), 32'd0);
   endtask

   task automatic run_flush(input logic [31:0] a, input int kf);
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = a;
      for (int k = 1; k <= kf; k++) begin
         tick();
         check("fl_busy_pre", 32'(bus.busy_o), 32'd1);
         check("fl_done_pre", 32'(bus.if_done_o), 32'd0);
      end
      bus.if_flush_i = 1'b1;
      bus.if_req_i   = 1'b0;
      tick();
      bus.if_flush_i = 1'b0;
      check("fl_busy", 32'(bus.busy_o), 32'd0);
      check("fl_addr", bus.mem_a_o, 32'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("fl_no_done", 32'(bus.if_done_o), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      rst = 1'b1;
      bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0; bus.if_flush_i = 1'b0;
      bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'd0;
      bus.mem_len_i = 2'b00; bus.mem_wdata_i = 32'd0; bus.mem_din_i = 8'd0;
      bus.io_buffer_full_i = 1'b0;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
      for (int i = 0; i < 4; i++) ref_mem[i] = ram[i];
      ram[8'h10] = 8'h80;
      ref_mem[8'h10] = 8'h80;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_a", bus.mem_a_o, 32'd0);
      check("rst_dout", 32'(bus.mem_dout_o), 32'd0);
      check("rst_wr", 32'(bus.mem_wr_o), 32'd0);
      check("rst_if_done", 32'(bus.if_done_o), 32'd0);
      check("rst_if_inst", bus.if_inst_o, 32'd0);
      check("rst_mem_done", 32'(bus.mem_done_o), 32'd0);
      check("rst_rdata", bus.mem_rdata_o, 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);

      run_txn(1'b1, 1'b0, 32'h100, 2'b10, 32'd0, 8'd0, 1'b0);
      check("tp_if_inst", bus.if_inst_o, 32'h00000513);
      run_txn(1'b0, 1'b1, 32'h200, 2'b10, 32'h12345678, 8'd0, 1'b0);

      // contention: MEM load byte wins, IF follows in the MEM done cycle
      bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h10;
      bus.mem_len_i = 2'b00; bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("ct_mem_done", 32'(bus.mem_done_o), 32'(k == 3));
         check("ct_if_done", 32'(bus.if_done_o), 32'(k == 9));
         if (k == 3) check("ct_rdata", bus.mem_rdata_o, 32'h00000080);
         if (k == 4) begin
            check("ct_if_addr", bus.mem_a_o, 32'h40);
            bus.mem_req_i = 1'b0;
         end
      end
      check("ct_inst", bus.if_inst_o, model_read(32'h40, 4));
      bus.if_req_i = 1'b0;
      tick();
      check("ct_idle", 32'(bus.busy_o), 32'd0);

      run_flush(32'h40, 2);
      run_txn(1'b1, 1'b0, 32'h80, 2'b10, 32'd0, 8'd0, 1'b0);
      run_txn(1'b0, 1'b1, 32'h30000, 2'b00, 32'h41, 8'b0000_0111, 1'b0);

      // reset in the middle of a word store: two bytes already strobed
      bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h200;
      bus.mem_len_i = 2'b10; bus.mem_wdata_i = 32'hA1B2C3D4;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_req_i = 1'b0;
      check("mr_wr", 32'(bus.mem_wr_o), 32'd0);
      check("mr_busy", 32'(bus.busy_o), 32'd0);
      check("mr_done", 32'(bus.mem_done_o), 32'd0);
      check("mr_a", bus.mem_a_o, 32'd0);
      check("mr_dout", 32'(bus.mem_dout_o), 32'd0);
      check("mr_inst", bus.if_inst_o, 32'd0);
      check("mr_rdata", bus.mem_rdata_o, 32'd0);
      ref_mem[8'h00] = 8'hD4;
      ref_mem[8'h01] = 8'hC3;
      tick();
      check("mr_idle", 32'(bus.busy_o), 32'd0);
      run_txn(1'b0, 1'b0, 32'h200, 2'b10, 32'd0, 8'd0, 1'b0);

      run_txn(1'b0, 1'b1, 32'hFFFFFFFE, 2'b10, 32'hCAFEF00D, 8'd0, 1'b0);
      run_txn(1'b0, 1'b0, 32'hFFFFFFFE, 2'b11, 32'd0, 8'd0, 1'b0);

      // flush together with a new IF request while idle: no grant
      bus.if_req_i = 1'b1; bus.if_flush_i = 1'b1; bus.if_addr_i = 32'h44;
      tick();
      check("fq_busy", 32'(bus.busy_o), 32'd0);
      bus.if_req_i = 1'b0; bus.if_flush_i = 1'b0;
      tick();
      check("fq_idle", 32'(bus.busy_o), 32'd0);

      for (int t = 0; t < 80; t++) begin
         r = $urandom_range(9);
         a = $urandom;
         if ($urandom_range(3) == 0) a[17:16] = 2'b11;
         if ($urandom_range(9) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(3));
         if (r < 2)
            run_txn(1'b1, 1'b0, a, 2'b10, 32'd0, 8'($urandom), 1'b1);
         else if (r == 2)
            run_flush(a, $urandom_range(5, 1));
         else if (r < 6)
            run_txn(1'b0, 1'b0, a, 2'($urandom), 32'd0, 8'($urandom), 1'b1);
         else
            run_txn(1'b0, 1'b1, a, 2'($urandom), $urandom, 8'($urandom), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
